// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among N_REQ writeback sources.
// Optional REGFILE_ARB_STATS_EN adds a conflict_cnt port counting multi-requester cycles.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_stall,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic                      wEnable,
  output logic [ADDR_W-1:0]         wAddr,
  output logic [DATA_W-1:0]         wData
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [31:0]               conflict_cnt
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gidx;
  logic              grant;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin : grant_sel
    int idx;
    idx       = 0;
    gidx      = '0;
    grant     = 1'b0;
    req_ready = '0;
    if (!rst && !wb_stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grant && req_valid[idx]) begin
          grant = 1'b1;
          gidx  = PTR_W'(idx);
        end
      end
      if (grant) req_ready[gidx] = 1'b1;
    end
  end

  assign g_addr = req_addr[gidx*ADDR_W +: ADDR_W];
  assign g_data = req_data[gidx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      wEnable <= 1'b0;
      wAddr   <= '0;
      wData   <= '0;
      rr_ptr  <= '0;
    end else if (grant) begin
      // x0 writes are consumed but never reach the regfile
      wEnable <= (g_addr != '0);
      wAddr   <= g_addr;
      wData   <= g_data;
      rr_ptr  <= (gidx == PTR_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
    end else begin
      wEnable <= 1'b0;
      wAddr   <= '0;
      wData   <= '0;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      conflict_cnt <= '0;
    else if ($countones(req_valid) >= 2)
      conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a distance-based
// round-robin reference model.
module tb_regfile_wb_arbiter;
  localparam int N      = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wb_stall;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  logic [N*ADDR_W-1:0]     req_addr;
  logic [N*DATA_W-1:0]     req_data;
  logic                    wEnable;
  logic [ADDR_W-1:0]       wAddr;
  logic [DATA_W-1:0]       wData;
`ifdef REGFILE_ARB_STATS_EN
  logic [31:0]             conflict_cnt;
`endif

  logic [ADDR_W-1:0] a_in [N];
  logic [DATA_W-1:0] d_in [N];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = a_in[i];
      req_data[i*DATA_W +: DATA_W] = d_in[i];
    end
  end

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .wEnable(wEnable), .wAddr(wAddr), .wData(wData)
`ifdef REGFILE_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference state: priority origin and conflict counter
  int           m_ptr = 0;
  int           last_g = -1;
  logic [31:0]  m_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check same-cycle grant, then registered outputs after the edge.
  task automatic cycle();
    int g, best, d, nv;
    logic [N-1:0]      e_ready;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    #1;
    g = -1; best = N; nv = 0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        nv++;
        d = (i - m_ptr + N) % N;
        if (d < best) begin best = d; g = i; end
      end
    end
    if (rst || wb_stall) g = -1;
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    e_we = 1'b0; e_addr = '0; e_data = '0;
    if (rst) begin
      m_ptr = 0;
      m_cnt = '0;
    end else begin
      if (g >= 0) begin
        e_addr = a_in[g];
        e_data = d_in[g];
        e_we   = (a_in[g] != 0);
        m_ptr  = (g + 1) % N;
      end
      if (nv >= 2) m_cnt = m_cnt + 1;
    end
    last_g = g;
    @(posedge clk);
    #1;
    chk("wEnable", 64'(wEnable), 64'(e_we));
    chk("wAddr",   64'(wAddr),   64'(e_addr));
    chk("wData",   64'(wData),   64'(e_data));
`ifdef REGFILE_ARB_STATS_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic set_all(input logic [N-1:0] v);
    req_valid = v;
  endtask

  initial begin
    rst = 1'b1; wb_stall = 1'b0; req_valid = '1;
    for (int i = 0; i < N; i++) begin a_in[i] = ADDR_W'(i + 1); d_in[i] = 32'h100 + i; end

    // Reset held two cycles with every requester valid
    cycle(); cycle();

    // Single requester, then idle
    rst = 1'b0; req_valid = 3'b010; a_in[1] = 5'd7; d_in[1] = 32'hDEADBEEF;
    cycle();
    req_valid = '0;
    cycle();

    // Round-robin from pointer 0 with all valid
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin a_in[i] = ADDR_W'(i + 1); d_in[i] = $urandom; end
    req_valid = '1;
    repeat (4) cycle();

    // x0 write is consumed and dropped; pointer then wraps to 0
    rst = 1'b1; cycle(); rst = 1'b0;
    req_valid = 3'b100; a_in[2] = '0; d_in[2] = 32'h5;
    cycle();
    a_in[2] = 5'd3; req_valid = '1;
    cycle();

    // Stall for three cycles holds the pointer, release resumes there
    wb_stall = 1'b1;
    repeat (3) cycle();
    wb_stall = 1'b0;
    repeat (2) cycle();

    // Randomized requesters obeying hold-until-ready, with occasional drops, stalls, resets
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_g == i) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          a_in[i] = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
          d_in[i] = $urandom;
        end
      end
      wb_stall = ($urandom_range(0, 4) == 0);
      rst      = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0; wb_stall = 1'b0;

`ifdef REGFILE_ARB_STATS_EN
    rst = 1'b1; cycle(); rst = 1'b0;
    wb_stall = 1'b1; req_valid = 3'b011;
    repeat (10) cycle();
    chk("conflict_cnt_10", 64'(conflict_cnt), 64'd10);
    force dut.conflict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt;
    m_cnt = 32'hFFFF_FFFE;
    cycle();
    cycle();
    chk("conflict_cnt_wrap", 64'(conflict_cnt), 64'd0);
    wb_stall = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
